vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen_pkg.sv | 33 +++
 rtl/vga_timing_gen_pixel_tick_div.sv | 28 ++
 rtl/vga_timing_gen.sv | 79 +++++++
 tb/tb_vga_timing_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 timing constants and the coordinate type.
// The pixel generator uses the same constants, so they live here.
package vga_timing_pkg;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned CLK_DIV   = 4;

    localparam int unsigned H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START     = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END       = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START     = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END       = VS_START + V_SYNC - 1;
    localparam int unsigned FRAME_TICK_Y = V_DISPLAY + 1;
    localparam int unsigned X_MAX        = H_TOTAL - 1;
    localparam int unsigned Y_MAX        = V_TOTAL - 1;

    localparam int unsigned COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Inclusive window test used for the sync pulse decodes.
    function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick_div.sv
// Pixel-rate strobe: one clk high out of every CLK_DIV system clocks.
module pixel_tick_div #(
    parameter int unsigned CLK_DIV = vga_timing_pkg::CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);
    import vga_timing_pkg::*;

    localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    // Free-running divider, wraps after CLK_DIV-1.
    always_ff @(posedge clk) begin
        if (reset)
            div <= '0;
        else if (div == DIV_LAST)
            div <= '0;
        else
            div <= div + DW'(1);
    end

    assign p_tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters plus registered sync, blanking
// and frame strobe outputs, all aligned to the counters they describe.
module vga_timing_gen #(
    parameter int unsigned H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
    parameter int unsigned V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK,
    parameter int unsigned CLK_DIV   = vga_timing_pkg::CLK_DIV
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);
    import vga_timing_pkg::*;

    localparam coord_t X_LAST = coord_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t Y_LAST = coord_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t X_VIS  = coord_t'(H_DISPLAY);
    localparam coord_t Y_VIS  = coord_t'(V_DISPLAY);
    localparam coord_t HS_LO  = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_HI  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_LO  = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_HI  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam coord_t FT_Y   = coord_t'(V_DISPLAY + 1);

    coord_t x_next;
    coord_t y_next;

    pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    // Next raster position; advances only on the pixel strobe.
    always_comb begin
        x_next = x;
        y_next = y;
        if (p_tick) begin
            if (x == X_LAST) begin
                x_next = '0;
                y_next = (y == Y_LAST) ? '0 : y + coord_t'(1);
            end else begin
                x_next = x + coord_t'(1);
            end
        end
    end

    // Counters and decodes share one register stage; decoding the next
    // position keeps sync/blank changes in the same clk as x/y.
    always_ff @(posedge clk) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            video_on   <= 1'b1;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            x          <= x_next;
            y          <= y_next;
            video_on   <= (x_next < X_VIS) && (y_next < Y_VIS);
            hsync      <= !in_range(x_next, HS_LO, HS_HI);
            vsync      <= !in_range(y_next, VS_LO, VS_HI);
            frame_tick <= p_tick && (x_next == '0) && (y_next == FT_Y);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-timing instance for line-level behaviour and a
// shrunken-timing instance (25x19 raster) so whole frames fit a short run.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       reset, reset_s;
    logic       p_tick, video_on, hsync, vsync, frame_tick;
    logic [9:0] x, y;
    logic       p_tick_s, video_on_s, hsync_s, vsync_s, frame_tick_s;
    logic [9:0] x_s, y_s;

    int errors = 0;
    int checks = 0;
    bit sweep_on = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .x(x), .y(y),
        .video_on(video_on), .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick)
    );

    vga_timing_gen #(
        .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CLK_DIV(4)
    ) dut_s (
        .clk(clk), .reset(reset_s), .p_tick(p_tick_s), .x(x_s), .y(y_s),
        .video_on(video_on_s), .hsync(hsync_s), .vsync(vsync_s), .frame_tick(frame_tick_s)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sweep(input string tag, input int xv, input int yv,
                         input logic von, input logic hs, input logic vs,
                         input int hd, input int vd, input int hlo, input int hhi,
                         input int vlo, input int vhi, input int xm, input int ym);
        chk({tag, " sweep video_on"}, int'(von), int'(xv < hd && yv < vd));
        chk({tag, " sweep hsync"},    int'(hs),  int'(!(xv >= hlo && xv <= hhi)));
        chk({tag, " sweep vsync"},    int'(vs),  int'(!(yv >= vlo && yv <= vhi)));
        chk({tag, " sweep x<=max"},   int'(xv <= xm), 1);
        chk({tag, " sweep y<=max"},   int'(yv <= ym), 1);
    endtask

    // Per-clk invariants sampled on the inactive edge.
    always @(negedge clk) begin
        if (sweep_on) begin
            sweep("dflt", int'(x), int'(y), video_on, hsync, vsync,
                  640, 480, 656, 751, 490, 491, 799, 524);
            sweep("small", int'(x_s), int'(y_s), video_on_s, hsync_s, vsync_s,
                  16, 12, 18, 21, 14, 15, 24, 18);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    typedef struct {
        int   tick;
        int   ex;
        int   ey;
        logic von;
        logic hs;
        logic vs;
    } vec_t;

    vec_t tbl[13];
    int   exp_pt[8];
    int   e, es, lo, vlo;
    int   ft_q[$];

    initial begin
        exp_pt = '{0, 0, 0, 1, 0, 0, 0, 1};
        // pixel ticks since reset release -> expected raster state
        tbl[0]  = '{2,    2,   0,  1'b1, 1'b1, 1'b1};
        tbl[1]  = '{639,  639, 0,  1'b1, 1'b1, 1'b1};
        tbl[2]  = '{640,  640, 0,  1'b0, 1'b1, 1'b1};
        tbl[3]  = '{655,  655, 0,  1'b0, 1'b1, 1'b1};
        tbl[4]  = '{656,  656, 0,  1'b0, 1'b0, 1'b1};
        tbl[5]  = '{751,  751, 0,  1'b0, 1'b0, 1'b1};
        tbl[6]  = '{752,  752, 0,  1'b0, 1'b1, 1'b1};
        tbl[7]  = '{799,  799, 0,  1'b0, 1'b1, 1'b1};
        tbl[8]  = '{800,  0,   1,  1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1439, 639, 1,  1'b1, 1'b1, 1'b1};
        tbl[10] = '{1440, 640, 1,  1'b0, 1'b1, 1'b1};
        tbl[11] = '{8799, 799, 10, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{8800, 0,   11, 1'b1, 1'b1, 1'b1};

        reset   = 1'b1;
        reset_s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst x", int'(x), 0);
        chk("rst y", int'(y), 0);
        chk("rst p_tick", int'(p_tick), 0);
        chk("rst video_on", int'(video_on), 1);
        chk("rst hsync", int'(hsync), 1);
        chk("rst vsync", int'(vsync), 1);
        chk("rst frame_tick", int'(frame_tick), 0);
        sweep_on = 1;

        // Release: p_tick seen before each edge, x after it.
        reset = 1'b0;
        e = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("release p_tick before edge %0d", k), int'(p_tick), exp_pt[k-1]);
            @(posedge clk);
            e++;
            #1;
            chk($sformatf("release x after edge %0d", k), int'(x), k / 4);
        end

        for (int i = 0; i < 13; i++) begin
            while (e < 4 * tbl[i].tick) begin
                @(posedge clk);
                e++;
            end
            #1;
            chk($sformatf("tbl%0d x", i), int'(x), tbl[i].ex);
            chk($sformatf("tbl%0d y", i), int'(y), tbl[i].ey);
            chk($sformatf("tbl%0d video_on", i), int'(video_on), int'(tbl[i].von));
            chk($sformatf("tbl%0d hsync", i), int'(hsync), int'(tbl[i].hs));
            chk($sformatf("tbl%0d vsync", i), int'(vsync), int'(tbl[i].vs));
            chk($sformatf("tbl%0d p_tick", i), int'(p_tick), 0);
        end

        // One full line (y=11): hsync low width in clk.
        lo = 0;
        repeat (3200) begin
            @(posedge clk);
            e++;
            #1;
            if (!hsync) lo++;
        end
        chk("hsync low clk", lo, 384);
        chk("line end x", int'(x), 0);
        chk("line end y", int'(y), 12);

        // Reset while an update to x=301 is pending.
        while (e < 39600) begin
            @(posedge clk);
            e++;
        end
        #1;
        chk("pre-rst x", int'(x), 300);
        chk("pre-rst y", int'(y), 12);
        while (e < 39603) begin
            @(posedge clk);
            e++;
        end
        #1;
        chk("pre-rst pending p_tick", int'(p_tick), 1);
        reset = 1'b1;
        @(posedge clk);
        e++;
        #1;
        chk("midrst x", int'(x), 0);
        chk("midrst y", int'(y), 0);
        chk("midrst p_tick", int'(p_tick), 0);
        chk("midrst video_on", int'(video_on), 1);
        chk("midrst hsync", int'(hsync), 1);
        chk("midrst vsync", int'(vsync), 1);
        chk("midrst frame_tick", int'(frame_tick), 0);
        reset = 1'b0;

        // Small raster: 100 clk/line, 1900 clk/frame, frame strobe at (0,13).
        reset_s = 1'b0;
        es  = 0;
        vlo = 0;
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            es++;
            #1;
            if (frame_tick_s) begin
                ft_q.push_back(es);
                chk("frame_tick x", int'(x_s), 0);
                chk("frame_tick y", int'(y_s), 13);
            end
            if (!vsync_s) vlo++;
            if (es == 1896) begin
                chk("wrap pre x", int'(x_s), 24);
                chk("wrap pre y", int'(y_s), 18);
            end
            if (es == 1900) begin
                chk("wrap x", int'(x_s), 0);
                chk("wrap y", int'(y_s), 0);
                chk("wrap vsync", int'(vsync_s), 1);
            end
        end
        chk("frame_tick pulses", ft_q.size(), 2);
        chk("frame_tick first edge", (ft_q.size() > 0) ? ft_q[0] : -1, 1300);
        chk("frame_tick spacing", (ft_q.size() > 1) ? ft_q[1] - ft_q[0] : -1, 1900);
        chk("vsync low clk over 2 frames", vlo, 400);

        // Reset inside hsync+vsync pulse with an update pending.
        while (es < 5279) begin
            @(posedge clk);
            es++;
        end
        #1;
        chk("s pre-rst x", int'(x_s), 19);
        chk("s pre-rst y", int'(y_s), 14);
        chk("s pre-rst hsync", int'(hsync_s), 0);
        chk("s pre-rst vsync", int'(vsync_s), 0);
        chk("s pre-rst video_on", int'(video_on_s), 0);
        chk("s pre-rst p_tick", int'(p_tick_s), 1);
        reset_s = 1'b1;
        @(posedge clk);
        es++;
        #1;
        chk("s midrst x", int'(x_s), 0);
        chk("s midrst y", int'(y_s), 0);
        chk("s midrst hsync", int'(hsync_s), 1);
        chk("s midrst vsync", int'(vsync_s), 1);
        chk("s midrst video_on", int'(video_on_s), 1);
        chk("s midrst p_tick", int'(p_tick_s), 0);
        chk("s midrst frame_tick", int'(frame_tick_s), 0);
        reset_s = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
